// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock on sout/sout_en.
// Define PISO_TX_LSB_FIRST_EN to send bit 0 first; the default build sends the MSB first.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sout,
    output logic             sout_en,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shreg_shifted;

`ifdef PISO_TX_LSB_FIRST_EN
    assign first_bit     = load_data[0];
    assign load_rest     = {1'b0, load_data[WIDTH-1:1]};
    assign next_bit      = shreg[0];
    assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
`else
    assign first_bit     = load_data[WIDTH-1];
    assign load_rest     = {load_data[WIDTH-2:0], 1'b0};
    assign next_bit      = shreg[WIDTH-1];
    assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A new word may start in the last-bit cycle, so SHIFT only falls back to IDLE without an accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if ((cnt == '0) && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // load_ready depends only on registers, never on load_valid.
    always_comb begin
        last       = (state == SHIFT) && (cnt == '0);
        load_ready = (state == IDLE) || last;
        accept     = load_valid && load_ready;
        done       = sout_en && last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            sout    <= 1'b0;
            sout_en <= 1'b0;
        end else if (accept) begin
            shreg   <= load_rest;
            cnt     <= CNT_MAX;
            sout    <= first_bit;
            sout_en <= 1'b1;
        end else if ((state == SHIFT) && (cnt != '0)) begin
            shreg   <= shreg_shifted;
            cnt     <= cnt - CW'(1);
            sout    <= next_bit;
        end else if (state == SHIFT) begin
            sout    <= 1'b0;
            sout_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an 8-bit and a 2-bit instance checked each cycle against a bit-queue model.
// The model follows PISO_TX_LSB_FIRST_EN so the same bench covers both bit orders.
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, sout, sout_en, done;
    logic       lv2 = 1'b0;
    logic [1:0] ld2 = '0;
    logic       lr2, so2, se2, dn2;

    int passed = 0;
    int total  = 0;

    // Bits still owed by each transmitter; the front is the bit on sout this cycle.
    bit q8[$];
    bit q2[$];

    piso_tx #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .sout(sout), .sout_en(sout_en), .done(done)
    );

    piso_tx #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2),
        .load_data(ld2), .sout(so2), .sout_en(se2), .done(dn2)
    );

    always #5 clk = ~clk;

    // Expected {sout, sout_en, done, load_ready} derived from the queue occupancy.
    function automatic logic [3:0] exp8();
        return {(q8.size() != 0) ? logic'(q8[0]) : 1'b0, q8.size() != 0, q8.size() == 1, q8.size() <= 1};
    endfunction

    function automatic logic [3:0] exp2();
        return {(q2.size() != 0) ? logic'(q2[0]) : 1'b0, q2.size() != 0, q2.size() == 1, q2.size() <= 1};
    endfunction

    // Drive inputs at the falling edge, advance one rising edge, update the model, return at the next falling edge.
    task automatic tick(input logic v8, input logic [7:0] d8, input logic v2, input logic [1:0] d2);
        bit acc8, acc2;
        load_valid = v8;
        load_data  = d8;
        lv2        = v2;
        ld2        = d2;
        acc8 = v8 && (q8.size() <= 1);
        acc2 = v2 && (q2.size() <= 1);
        @(posedge clk);
        if (q8.size() != 0) void'(q8.pop_front());
        if (q2.size() != 0) void'(q2.pop_front());
        if (acc8)
            for (int i = 0; i < 8; i++)
`ifdef PISO_TX_LSB_FIRST_EN
                q8.push_back(d8[i]);
`else
                q8.push_back(d8[7-i]);
`endif
        if (acc2)
            for (int i = 0; i < 2; i++)
`ifdef PISO_TX_LSB_FIRST_EN
                q2.push_back(d2[i]);
`else
                q2.push_back(d2[1-i]);
`endif
        @(negedge clk);
        load_valid = 1'b0;
        lv2        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        q8.delete();
        q2.delete();
        total++;
        if ({sout, sout_en, done, load_ready} !== 4'b0001)
            $display("[TB] FAIL reset8: got %b expected 0001", {sout, sout_en, done, load_ready});
        else passed++;
        total++;
        if ({so2, se2, dn2, lr2} !== 4'b0001)
            $display("[TB] FAIL reset2: got %b expected 0001", {so2, se2, dn2, lr2});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word(input logic [7:0] w);
        tick(1'b1, w, 1'b0, 2'b00);
        for (int c = 1; c <= 9; c++) begin
            total++;
            if ({sout, sout_en, done, load_ready} !== exp8())
                $display("[TB] FAIL single %h cycle %0d: got %b expected %b", w, c,
                         {sout, sout_en, done, load_ready}, exp8());
            else passed++;
            tick(1'b0, 8'h00, 1'b0, 2'b00);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 1; c <= 18; c++) begin
            tick(c <= 9, (c <= 8) ? 8'hA5 : 8'h3C, 1'b0, 2'b00);
            total++;
            if ({sout, sout_en, done, load_ready} !== exp8())
                $display("[TB] FAIL b2b cycle %0d: got %b expected %b", c,
                         {sout, sout_en, done, load_ready}, exp8());
            else passed++;
        end
    endtask

    task automatic test_busy_ignore();
        tick(1'b1, 8'hFF, 1'b0, 2'b00);
        for (int c = 1; c <= 10; c++) begin
            total++;
            if ({sout, sout_en, done, load_ready} !== exp8())
                $display("[TB] FAIL busy cycle %0d: got %b expected %b", c,
                         {sout, sout_en, done, load_ready}, exp8());
            else passed++;
            tick((c >= 1) && (c <= 4), 8'h00, 1'b0, 2'b00);
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, 8'hA5, 1'b0, 2'b00);
        tick(1'b0, 8'h00, 1'b0, 2'b00);
        tick(1'b0, 8'h00, 1'b0, 2'b00);
        tick(1'b0, 8'h00, 1'b0, 2'b00);
        rst = 1'b1;
        #1;
        q8.delete();
        total++;
        if ({sout, sout_en, done, load_ready} !== 4'b0001)
            $display("[TB] FAIL midreset: got %b expected 0001", {sout, sout_en, done, load_ready});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        test_single_word(8'h81);
    endtask

    task automatic test_width2();
        tick(1'b0, 8'h00, 1'b1, 2'b10);
        for (int c = 1; c <= 6; c++) begin
            total++;
            if ({so2, se2, dn2, lr2} !== exp2())
                $display("[TB] FAIL w2 cycle %0d: got %b expected %b", c, {so2, se2, dn2, lr2}, exp2());
            else passed++;
            tick(1'b0, 8'h00, c == 1, 2'b01);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, 2'($urandom));
            total++;
            if ({sout, sout_en, done, load_ready} !== exp8())
                $display("[TB] FAIL rand8 cycle %0d: got %b expected %b", c,
                         {sout, sout_en, done, load_ready}, exp8());
            else passed++;
            total++;
            if ({so2, se2, dn2, lr2} !== exp2())
                $display("[TB] FAIL rand2 cycle %0d: got %b expected %b", c, {so2, se2, dn2, lr2}, exp2());
            else passed++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word(8'hA5);
        test_single_word(8'h01);
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_width2();
        test_random();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on `sout`, qualified by `sout_en`. `sout`/`sout_en` drive the `din`/`en` inputs of our enabled-D-flip-flop capture chain, so this block is the transmitting end of the serial link.

## Interface
- `WIDTH`, default 8: word width in bits. Legal range is WIDTH >= 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  a word is offered on `load_data`.
- `load_ready`  out  1  the block can accept a word this cycle.
- `load_data`  in  WIDTH  word to transmit; sampled only on an accepted load.
- `sout`  out  1  serial data bit (registered).
- `sout_en`  out  1  `sout` holds a valid bit this cycle (registered).
- `done`  out  1  high during the cycle that carries the last bit of a word.

## Operation
- State machine has two states.
  - IDLE: `sout_en`=0 and `sout`=0.
  - SHIFT: one bit is driven per cycle.
- Registers:
  - `shreg[WIDTH-1:0]`.
  - `cnt[$clog2(WIDTH)-1:0]`, which holds the number of bits remaining after the current one.
- `load_ready` = (state==IDLE) || (state==SHIFT && cnt==0). It is combinational from registers only and has no path from `load_valid`.
- Accept = `load_valid && load_ready`. On accept:
  - state goes to SHIFT.
  - The first bit of `load_data` is registered onto `sout` and `sout_en`=1.
  - The remaining bits are placed in `shreg`.
  - `cnt` = WIDTH-1.
- In SHIFT with cnt!=0: the next bit goes onto `sout`, `shreg` shifts, and `cnt` decrements.
- In SHIFT with cnt==0 and no accept: go to IDLE, `sout_en`=0, `sout`=0.
- In SHIFT with cnt==0 and accept: start the new word on the next edge. There is no idle gap between words.
- `done` = `sout_en && state==SHIFT && cnt==0`.
- `load_valid` while `load_ready`=0 is ignored. Data is not latched and the word in flight is not disturbed.
- Reset at any time aborts the word in flight. The partial word is dropped and is not resumed.
- Reset values:
  - state = IDLE.
  - `sout`=0, `sout_en`=0.
  - `shreg`=0, `cnt`=0.
  - Hence `load_ready`=1 and `done`=0.

## Timing
- Latency: on an accept at edge k, the first bit is valid on `sout` from edge k until edge k+1. The last bit is valid from edge k+WIDTH-1 until edge k+WIDTH.
- A word occupies exactly WIDTH consecutive cycles with `sout_en`=1.
- Throughput: one bit per clock. With continuous accepts, `sout_en` stays high indefinitely.
- `load_ready` goes high in the last-bit cycle, together with `done`.
- The earliest next accept is the edge that ends the last bit.
- The receiver samples `sout` on the rising edge while `sout_en`=1. Bit i of a word is captured at edge k+1+i.
- Reset assertion clears the outputs immediately, without waiting for a clock edge.
- After reset deasserts, the first accept can occur at the first rising edge.

## Configuration
- `PISO_TX_LSB_FIRST_EN` not defined (default): MSB first. The first bit is `load_data[WIDTH-1]` and `shreg` shifts left.
- `PISO_TX_LSB_FIRST_EN` defined: LSB first. The first bit is `load_data[0]` and `shreg` shifts right.
- Handshake, latency and `done` timing are identical in both builds.

## Test plan
- MSB-first, WIDTH=8. Load 8'hA5 from IDLE. Required: `sout` = 1,0,1,0,0,1,0,1 over 8 cycles with `sout_en`=1. `done` is high only in cycle 8. `load_ready`=0 in cycles 1–7.
- Back-to-back. Hold `load_valid`=1 with 8'hA5 then 8'h3C. Required: 16 consecutive `sout_en`=1 cycles carrying A5 then 3C. `done` pulses in cycles 8 and 16. `sout_en`=0 in cycle 17.
- Busy-ignore. Load 8'hFF, then present 8'h00 with `load_valid`=1 during cycles 2–5 only. Required: eight 1-bits go out, then IDLE. The 8'h00 word is never transmitted.
- Reset mid-frame. Load 8'hA5 and assert `rst` after the 3rd bit. Required: `sout`=0, `sout_en`=0 and `load_ready`=1 immediately. After release, load 8'h81: it transmits cleanly as 1,0,0,0,0,0,0,1.
- LSB-first build with `PISO_TX_LSB_FIRST_EN` defined. Load 8'hA5. Required: `sout` = 1,0,1,0,0,1,0,1 (bit0 first). Also load 8'h01. Required: 1 then seven 0s.
- WIDTH=2. Loads 2'b10, 2'b01 back-to-back. Required: `sout` = 1,0,0,1. `done` is high in cycles 2 and 4. `load_ready` is high in cycles 2 and 4 and again from cycle 5 in IDLE.
